// File: rtl/output_accum_memory_pkg.sv
// Shared constants and types for the per-slot output accumulator store.
package output_accum_memory_pkg;

  localparam int unsigned OUTMEM_WIDTH  = 10;
  localparam int unsigned OUTMEM_DEPTH  = 18;
  localparam int unsigned OUTMEM_ADDR_W = 5;

  typedef logic signed [OUTMEM_WIDTH-1:0] signed_li_t;

endpackage

// File: rtl/output_accum_memory_if.sv
// Write/read bus of the output accumulator store.
interface output_accum_memory_if #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned ADDR_W = 5
);
  logic              clear;
  logic              busy;
  logic              wr;
  logic              wmode;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;
  logic [ADDR_W-1:0] addr2;
  logic [WIDTH-1:0]  rdata2;
  logic              sat;

  modport master (
    output clear, wr, wmode, addr, wdata, addr2,
    input  busy, rdata, rdata2, sat
  );

  modport slave (
    input  clear, wr, wmode, addr, wdata, addr2,
    output busy, rdata, rdata2, sat
  );
endinterface

// File: rtl/output_accum_memory_sat_add_signed.sv
// Combinational signed adder clamping to the WIDTH-bit two's complement range.
module sat_add_signed #(
  parameter int unsigned WIDTH = 10
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // Top two bits disagree only when the true sum left the WIDTH-bit range.
    ovf = sum[WIDTH] ^ sum[WIDTH-1];
    y   = ovf ? {sum[WIDTH], {(WIDTH-1){~sum[WIDTH]}}} : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/output_accum_memory.sv
// Per-slot signed sample store with overwrite/saturating-accumulate writes,
// two registered read ports and a self-clearing sweep after reset or clear.
module output_accum_memory
  import output_accum_memory_pkg::*;
#(
  parameter int unsigned WIDTH  = OUTMEM_WIDTH,
  parameter int unsigned DEPTH  = OUTMEM_DEPTH,
  parameter int unsigned ADDR_W = OUTMEM_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output_accum_memory_if.slave  bus
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              sat_q;
  logic [WIDTH-1:0]  rdata_q;
  logic [WIDTH-1:0]  rdata2_q;

  logic             addr_ok;
  logic             addr2_ok;
  logic [WIDTH-1:0] rd_old;
  logic [WIDTH-1:0] rd2_old;
  logic [WIDTH-1:0] acc_sum;
  logic             acc_ovf;
  logic             wr_ok;
  logic             sweep_we;

  always_comb begin
    addr_ok  = 32'(bus.addr) < DEPTH;
    addr2_ok = 32'(bus.addr2) < DEPTH;
    rd_old   = addr_ok ? mem[bus.addr] : '0;
    rd2_old  = addr2_ok ? mem[bus.addr2] : '0;
    // clear outranks both the sweep step and a user write in the same cycle.
    sweep_we = busy_q && !bus.clear;
    wr_ok    = bus.wr && !busy_q && !bus.clear && addr_ok;
  end

  sat_add_signed #(
    .WIDTH(WIDTH)
  ) u_sat_add (
    .a  (rd_old),
    .b  (bus.wdata),
    .y  (acc_sum),
    .ovf(acc_ovf)
  );

  // Array is left out of reset; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem[bus.addr] <= bus.wmode ? acc_sum : bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      sat_q    <= 1'b0;
      rdata_q  <= '0;
      rdata2_q <= '0;
    end else begin
      if (bus.clear) begin
        cnt_q  <= '0;
        busy_q <= 1'b1;
        sat_q  <= 1'b0;
      end else if (busy_q) begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          busy_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (wr_ok && bus.wmode && acc_ovf) begin
        sat_q <= 1'b1;
      end

      rdata_q  <= busy_q ? '0 : rd_old;
      rdata2_q <= busy_q ? '0 : rd2_old;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.sat    = sat_q;
  assign bus.rdata  = rdata_q;
  assign bus.rdata2 = rdata2_q;

endmodule

// File: tb/tb_output_accum_memory.sv
// Directed self-checking bench for output_accum_memory (WIDTH=10, DEPTH=18).
module tb_output_accum_memory;

  localparam int unsigned WIDTH  = 10;
  localparam int unsigned DEPTH  = 18;
  localparam int unsigned ADDR_W = 5;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total;

  output_accum_memory_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_if ();

  output_accum_memory #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until busy drops, bounded; returns the number of edges taken.
  task automatic count_busy(output int n);
    n = 0;
    while (bus_if.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    repeat (3) tick();
    total++;
    if (bus_if.busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", bus_if.busy);
    else pass_cnt++;
    total++;
    if (bus_if.sat !== 1'b0) $display("FAIL reset_sat: got %b want 0", bus_if.sat);
    else pass_cnt++;
    total++;
    if (bus_if.rdata !== 10'h000 || bus_if.rdata2 !== 10'h000)
      $display("FAIL reset_rdata: got %h/%h want 000/000", bus_if.rdata, bus_if.rdata2);
    else pass_cnt++;
    reset_n = 1'b1;
    count_busy(n);
    total++;
    if (n != 18) $display("FAIL reset_sweep_len: got %0d want 18", n);
    else pass_cnt++;
    for (int i = 0; i < 18; i++) begin
      bus_if.addr  = ADDR_W'(i);
      bus_if.addr2 = ADDR_W'(17 - i);
      tick();
      total++;
      if (bus_if.rdata !== 10'h000 || bus_if.rdata2 !== 10'h000)
        $display("FAIL reset_zero[%0d]: got %h/%h want 000/000", i, bus_if.rdata,
                 bus_if.rdata2);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    bus_if.addr  = 5'd3;
    bus_if.wdata = 10'h155;
    bus_if.wmode = 1'b0;
    bus_if.wr    = 1'b1;
    tick();
    bus_if.wr = 1'b0;
    total++;
    if (bus_if.rdata !== 10'h000) $display("FAIL rdw_old: got %h want 000", bus_if.rdata);
    else pass_cnt++;
    tick();
    total++;
    if (bus_if.rdata !== 10'h155) $display("FAIL write_new: got %h want 155", bus_if.rdata);
    else pass_cnt++;
  endtask

  task automatic test_accum();
    int n;
    bus_if.addr  = 5'd5;
    bus_if.wdata = 10'd200;
    bus_if.wmode = 1'b1;
    bus_if.wr    = 1'b1;
    tick();
    total++;
    if (bus_if.rdata !== 10'h000) $display("FAIL acc_e1: got %h want 000", bus_if.rdata);
    else pass_cnt++;
    tick();
    total++;
    if (bus_if.rdata !== 10'h0C8) $display("FAIL acc_e2: got %h want 0c8", bus_if.rdata);
    else pass_cnt++;
    total++;
    if (bus_if.sat !== 1'b0) $display("FAIL acc_sat_early: got %b want 0", bus_if.sat);
    else pass_cnt++;
    tick();
    bus_if.wr = 1'b0;
    total++;
    if (bus_if.rdata !== 10'h190) $display("FAIL acc_e3: got %h want 190", bus_if.rdata);
    else pass_cnt++;
    total++;
    if (bus_if.sat !== 1'b1) $display("FAIL acc_sat: got %b want 1", bus_if.sat);
    else pass_cnt++;
    tick();
    total++;
    if (bus_if.rdata !== 10'h1FF) $display("FAIL acc_clamp: got %h want 1ff", bus_if.rdata);
    else pass_cnt++;
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    total++;
    if (bus_if.sat !== 1'b0 || bus_if.busy !== 1'b1)
      $display("FAIL clear_flags: got sat=%b busy=%b want sat=0 busy=1", bus_if.sat,
               bus_if.busy);
    else pass_cnt++;
    count_busy(n);
    total++;
    if (n != 18) $display("FAIL clear_sweep_len: got %0d want 18", n);
    else pass_cnt++;
    tick();
    total++;
    if (bus_if.rdata !== 10'h000) $display("FAIL clear_zeroed: got %h want 000", bus_if.rdata);
    else pass_cnt++;
  endtask

  task automatic test_neg_dual_port();
    bus_if.addr  = 5'd7;
    bus_if.wdata = 10'h2D4;  // -300
    bus_if.wmode = 1'b1;
    bus_if.wr    = 1'b1;
    tick();
    total++;
    if (bus_if.rdata !== 10'h000) $display("FAIL neg_e1: got %h want 000", bus_if.rdata);
    else pass_cnt++;
    tick();
    total++;
    if (bus_if.rdata !== 10'h2D4) $display("FAIL neg_e2: got %h want 2d4", bus_if.rdata);
    else pass_cnt++;
    total++;
    if (bus_if.sat !== 1'b1) $display("FAIL neg_sat: got %b want 1", bus_if.sat);
    else pass_cnt++;
    bus_if.addr  = 5'd5;
    bus_if.wdata = 10'h07B;
    bus_if.wmode = 1'b0;
    tick();
    bus_if.wr    = 1'b0;
    bus_if.addr2 = 5'd7;
    tick();
    total++;
    if (bus_if.rdata !== 10'h07B || bus_if.rdata2 !== 10'h200)
      $display("FAIL dual_port: got %h/%h want 07b/200", bus_if.rdata, bus_if.rdata2);
    else pass_cnt++;
    bus_if.addr2 = 5'd5;
    tick();
    total++;
    if (bus_if.rdata2 !== 10'h07B || bus_if.rdata !== 10'h07B)
      $display("FAIL same_addr: got %h/%h want 07b/07b", bus_if.rdata, bus_if.rdata2);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    bus_if.addr  = 5'd20;
    bus_if.wdata = 10'h0AA;
    bus_if.wmode = 1'b0;
    bus_if.wr    = 1'b1;
    tick();
    bus_if.wr = 1'b0;
    tick();
    total++;
    if (bus_if.rdata !== 10'h000) $display("FAIL oor_read: got %h want 000", bus_if.rdata);
    else pass_cnt++;
    bus_if.addr  = 5'd2;
    bus_if.addr2 = 5'd7;
    tick();
    total++;
    if (bus_if.rdata !== 10'h000 || bus_if.rdata2 !== 10'h200)
      $display("FAIL oor_untouched: got %h/%h want 000/200", bus_if.rdata, bus_if.rdata2);
    else pass_cnt++;
    total++;
    if (bus_if.sat !== 1'b1) $display("FAIL oor_sat: got %b want 1", bus_if.sat);
    else pass_cnt++;
  endtask

  task automatic test_clear_wr();
    int n;
    bus_if.clear = 1'b1;
    bus_if.wr    = 1'b1;
    bus_if.addr  = 5'd5;
    bus_if.wdata = 10'h3FF;
    bus_if.wmode = 1'b0;
    tick();
    bus_if.clear = 1'b0;
    bus_if.wr    = 1'b0;
    total++;
    if (bus_if.busy !== 1'b1 || bus_if.sat !== 1'b0)
      $display("FAIL clr_wr_flags: got busy=%b sat=%b want busy=1 sat=0", bus_if.busy,
               bus_if.sat);
    else pass_cnt++;
    tick();
    tick();
    total++;
    if (bus_if.rdata !== 10'h000) $display("FAIL busy_read: got %h want 000", bus_if.rdata);
    else pass_cnt++;
    // Entry 0 is already swept, so a write that leaked through would persist.
    bus_if.addr  = 5'd0;
    bus_if.wdata = 10'h055;
    bus_if.wr    = 1'b1;
    tick();
    bus_if.wr = 1'b0;
    count_busy(n);
    total++;
    if (n != 15) $display("FAIL busy_remaining: got %0d want 15", n);
    else pass_cnt++;
    bus_if.addr  = 5'd0;
    bus_if.addr2 = 5'd5;
    tick();
    total++;
    if (bus_if.rdata !== 10'h000 || bus_if.rdata2 !== 10'h000)
      $display("FAIL busy_wr_dropped: got %h/%h want 000/000", bus_if.rdata, bus_if.rdata2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    bus_if.addr  = 5'd4;
    bus_if.wdata = 10'h1FF;
    bus_if.wmode = 1'b0;
    bus_if.wr    = 1'b1;
    tick();
    bus_if.wdata = 10'h001;
    bus_if.wmode = 1'b1;
    tick();
    bus_if.wr = 1'b0;
    tick();
    total++;
    if (bus_if.rdata !== 10'h1FF || bus_if.sat !== 1'b1)
      $display("FAIL pre_reset: got %h sat=%b want 1ff sat=1", bus_if.rdata, bus_if.sat);
    else pass_cnt++;
    bus_if.wr = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    bus_if.wr = 1'b0;
    total++;
    if (bus_if.busy !== 1'b1 || bus_if.sat !== 1'b0 || bus_if.rdata !== 10'h000)
      $display("FAIL async_reset: got busy=%b sat=%b rdata=%h want 1/0/000", bus_if.busy,
               bus_if.sat, bus_if.rdata);
    else pass_cnt++;
    tick();
    reset_n = 1'b1;
    count_busy(n);
    total++;
    if (n != 18) $display("FAIL reset_mid_write_len: got %0d want 18", n);
    else pass_cnt++;
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    repeat (9) tick();
    total++;
    if (bus_if.busy !== 1'b1) $display("FAIL pre_mid_sweep: got %b want 1", bus_if.busy);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus_if.busy !== 1'b1 || bus_if.sat !== 1'b0 || bus_if.rdata2 !== 10'h000)
      $display("FAIL mid_sweep_reset: got busy=%b sat=%b rdata2=%h want 1/0/000",
               bus_if.busy, bus_if.sat, bus_if.rdata2);
    else pass_cnt++;
    tick();
    reset_n = 1'b1;
    count_busy(n);
    total++;
    if (n != 18) $display("FAIL mid_sweep_rerun_len: got %0d want 18", n);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt     = 0;
    total        = 0;
    reset_n      = 1'b0;
    bus_if.clear = 1'b0;
    bus_if.wr    = 1'b0;
    bus_if.wmode = 1'b0;
    bus_if.addr  = '0;
    bus_if.addr2 = '0;
    bus_if.wdata = '0;
    test_reset();
    test_write_read();
    test_accum();
    test_neg_dual_port();
    test_out_of_range();
    test_clear_wr();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
